lstm_bp_ctrl: RTL

Sequencer for the LSTM array-with-backpropagation datapath. It drives the datapath control strobes `sel`, `load_in`, `load_h`, `load_bp`, `load_t`, `wr` and the label address. One run consists of `NUM_ITERATIONS` forward timesteps, then label fetch, backprop settle and a single weight/bias write-back. It sits beside the array top and replaces testbench-driven strobes.

---
 rtl/lstm_pkg.sv | 16 +
 rtl/dwell_cnt.sv | 17 +
 rtl/lstm_bp_ctrl.sv | 80 ++++++++
 3 files changed

// File: rtl/lstm_pkg.sv
// lstm_pkg: FSM state encoding and run-length/counter-width helpers for lstm_bp_ctrl
package lstm_pkg;
  typedef enum logic [3:0] {
    S_IDLE, S_FILL, S_LOAD_IN, S_FWD, S_CAPT, S_LABEL, S_BP, S_WR, S_DONE
  } state_t;
  function automatic int run_cycles(int num, int num_iterations, int num_lstm, int lstm_lat, int bp_lat);
    return 1 + num_iterations * (num + lstm_lat + 2) + num_lstm + bp_lat + 2;
  endfunction
  function automatic int dwell_w(int num, int lstm_lat, int num_lstm, int bp_lat);
    int m;
    m = num > lstm_lat ? num : lstm_lat;
    m = m > num_lstm ? m : num_lstm;
    m = m > bp_lat ? m : bp_lat;
    return m > 1 ? $clog2(m) : 1;
  endfunction
endpackage

// File: rtl/dwell_cnt.sv
// dwell_cnt: loadable down-counter (clk, rst, load, val in; cnt, tc=cnt==0 out) timing each FSM dwell
module dwell_cnt #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] val,
  output logic [W-1:0] cnt,
  output logic         tc
);
  assign tc = cnt == '0;
  always_ff @(posedge clk)
    if (rst) cnt <= '0;
    else if (load) cnt <= val;
    else if (!tc) cnt <= cnt - 1'b1;
endmodule

// File: rtl/lstm_bp_ctrl.sv
// lstm_bp_ctrl: LSTM backprop run sequencer (start in; busy/done, sel/load_in/load_h/load_bp/load_t/wr strobes, label address, step out)
module lstm_bp_ctrl
  import lstm_pkg::*;
#(
  parameter int WIDTH          = 32,
  parameter int NUM            = 45,
  parameter int NUM_LSTM       = 8,
  parameter int NUM_ITERATIONS = 8,
  parameter int NUM_SEQ        = 2,
  parameter int LSTM_LAT       = 4,
  parameter int BP_LAT         = 4,
  localparam int SW = NUM_ITERATIONS > 1 ? $clog2(NUM_ITERATIONS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             sel,
  output logic             load_in,
  output logic             load_h,
  output logic             load_bp,
  output logic             load_t,
  output logic             wr,
  output logic [WIDTH-1:0] o_addr_t,
  output logic [SW-1:0]    o_step
);
  localparam int CW = dwell_w(NUM, LSTM_LAT, NUM_LSTM, BP_LAT);
  localparam int QW = NUM_SEQ > 1 ? $clog2(NUM_SEQ) : 1;
  state_t state, nxt;
  logic [SW-1:0] step;
  logic [QW-1:0] seq;
  logic [CW-1:0] ld_val, cnt;
  logic ld, tc, last;
  dwell_cnt #(.W(CW)) u_dwell (.clk, .rst, .load(ld), .val(ld_val), .cnt, .tc);
  assign last = step == SW'(NUM_ITERATIONS - 1);
  always_ff @(posedge clk)
    if (rst) begin
      state <= S_IDLE;
      step  <= '0;
      seq   <= '0;
    end else begin
      state <= nxt;
      if (state == S_IDLE && start) step <= '0;
      else if (state == S_CAPT && !last) step <= step + 1'b1;
      if (state == S_WR) seq <= seq == QW'(NUM_SEQ - 1) ? '0 : seq + 1'b1;
    end
  always_comb begin
    nxt    = state;
    ld     = 1'b0;
    ld_val = '0;
    case (state)
      S_IDLE:    if (start) begin nxt = S_FILL; ld = 1'b1; ld_val = CW'(NUM - 1); end
      S_FILL:    if (tc) nxt = S_LOAD_IN;
      S_LOAD_IN: begin nxt = S_FWD; ld = 1'b1; ld_val = CW'(LSTM_LAT - 1); end
      S_FWD:     if (tc) nxt = S_CAPT;
      S_CAPT:    begin
        nxt    = last ? S_LABEL : S_FILL;
        ld     = 1'b1;
        ld_val = last ? CW'(NUM_LSTM - 1) : CW'(NUM - 1);
      end
      S_LABEL:   if (tc) begin nxt = S_BP; ld = 1'b1; ld_val = CW'(BP_LAT - 1); end
      S_BP:      if (tc) nxt = S_WR;
      S_WR:      nxt = S_DONE;
      S_DONE:    nxt = S_IDLE;
      default:   nxt = S_IDLE;
    endcase
  end
  assign busy    = state != S_IDLE && state != S_DONE;
  assign done    = state == S_DONE;
  assign sel     = (state inside {S_FILL, S_LOAD_IN, S_FWD, S_CAPT}) && step != '0;
  assign load_in = state == S_LOAD_IN;
  assign load_h  = state == S_CAPT;
  assign load_bp = state == S_CAPT;
  assign load_t  = state == S_LABEL;
  assign wr      = state == S_WR;
  assign o_step  = step;
  // label counter runs down, so word index k = NUM_LSTM-1-cnt
  assign o_addr_t = load_t ? WIDTH'(seq) * WIDTH'(NUM_LSTM) + WIDTH'(NUM_LSTM - 1) - WIDTH'(cnt) : '0;
endmodule
